// File: rtl/addr_patch_pkg.sv
// Shared types and constants for the address-patch controller.
// The entry struct is sized by PATCH_ADDR_W, so the controller's ADDR_W must stay equal to it.
package addr_patch_pkg;

  localparam int PATCH_ADDR_W = 32;
  localparam int HIT_CNT_W    = 16;

  typedef struct packed {
    logic                    en;
    logic [PATCH_ADDR_W-1:0] match;
    logic [PATCH_ADDR_W-1:0] replace;
  } patch_entry_t;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/addr_patch_match.sv
// Combinational priority matcher: the lowest-index enabled entry whose match field equals addr_i wins.
// On a miss hit_o=0, idx_o=0 and repl_o=0.
module addr_patch_match
  import addr_patch_pkg::*;
#(
  parameter int NUM_PATCH = 4,
  parameter int IDX_W     = 2
) (
  input  patch_entry_t            entries_i [NUM_PATCH],
  input  logic [PATCH_ADDR_W-1:0] addr_i,
  output logic                    hit_o,
  output logic [IDX_W-1:0]        idx_o,
  output logic [PATCH_ADDR_W-1:0] repl_o
);

  logic [NUM_PATCH-1:0] hit_vec;

  for (genvar gi = 0; gi < NUM_PATCH; gi++) begin : g_cmp
    assign hit_vec[gi] = entries_i[gi].en && (entries_i[gi].match == addr_i);
  end

  // Walk from the top down so the lowest hitting index is the last one written.
  always_comb begin
    hit_o  = |hit_vec;
    idx_o  = '0;
    repl_o = '0;
    for (int i = NUM_PATCH - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        idx_o  = IDX_W'(i);
        repl_o = entries_i[i].replace;
      end
    end
  end

endmodule

// File: rtl/addr_patch_ctrl.sv
// Address-patch controller: patch table, sequenced clear FSM and a one-deep registered output stage.
// Optional per-entry saturating hit counters are built when ADDR_PATCH_HIT_CNT_EN is defined.
module addr_patch_ctrl
  import addr_patch_pkg::*;
#(
  parameter int ADDR_W    = PATCH_ADDR_W,
  parameter int NUM_PATCH = 4,
  parameter int IDX_W     = (NUM_PATCH > 1) ? $clog2(NUM_PATCH) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 si_valid_i,
  output logic                 si_ready_o,
  input  logic [ADDR_W-1:0]    si_addr_i,
  output logic                 mi_valid_o,
  input  logic                 mi_ready_i,
  output logic [ADDR_W-1:0]    mi_addr_o,
  output logic                 mi_patched_o,
  output logic [IDX_W-1:0]     mi_idx_o,
  input  logic                 ctl_we_i,
  input  logic [IDX_W-1:0]     ctl_idx_i,
  input  logic                 ctl_en_i,
  input  logic [ADDR_W-1:0]    ctl_pat_addr_i,
  input  logic [ADDR_W-1:0]    ctl_pat_data_i,
  input  logic                 ctl_clr_i,
  output logic                 ctl_busy_o,
  output logic [HIT_CNT_W-1:0] ctl_hit_cnt_o
);

  clr_state_e          state_q;
  logic [IDX_W-1:0]    clr_ptr_q;
  logic                busy_q;

  logic                mi_valid_q;
  logic [ADDR_W-1:0]   mi_addr_q;
  logic                mi_patched_q;
  logic [IDX_W-1:0]    mi_idx_q;

  patch_entry_t        entries [NUM_PATCH];
  logic                lk_hit;
  logic [IDX_W-1:0]    lk_idx;
  logic [ADDR_W-1:0]   lk_repl;

  logic                si_hs;
  logic                idx_ok;
  logic                wr_ok;
  logic                clearing;

  assign si_ready_o = (state_q == IDLE) && (!mi_valid_q || mi_ready_i);
  assign si_hs      = si_valid_i && si_ready_o;
  assign idx_ok     = 32'(ctl_idx_i) < NUM_PATCH;
  // A clear request in the same cycle takes precedence over a table write.
  assign wr_ok      = ctl_we_i && (state_q == IDLE) && !ctl_clr_i && idx_ok;
  assign clearing   = (state_q == CLEAR);

  assign mi_valid_o   = mi_valid_q;
  assign mi_addr_o    = mi_addr_q;
  assign mi_patched_o = mi_patched_q;
  assign mi_idx_o     = mi_idx_q;
  assign ctl_busy_o   = busy_q;

  addr_patch_match #(
    .NUM_PATCH (NUM_PATCH),
    .IDX_W     (IDX_W)
  ) u_match (
    .entries_i (entries),
    .addr_i    (si_addr_i),
    .hit_o     (lk_hit),
    .idx_o     (lk_idx),
    .repl_o    (lk_repl)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      clr_ptr_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ctl_clr_i) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
            busy_q    <= 1'b1;
          end
        end
        CLEAR: begin
          if (clr_ptr_q == IDX_W'(NUM_PATCH - 1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            clr_ptr_q <= clr_ptr_q + IDX_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mi_valid_q   <= 1'b0;
      mi_addr_q    <= '0;
      mi_patched_q <= 1'b0;
      mi_idx_q     <= '0;
    end else if (si_hs) begin
      mi_valid_q   <= 1'b1;
      mi_addr_q    <= lk_hit ? lk_repl : si_addr_i;
      mi_patched_q <= lk_hit;
      mi_idx_q     <= lk_hit ? lk_idx : '0;
    end else if (mi_ready_i) begin
      mi_valid_q <= 1'b0;
    end
  end

`ifdef ADDR_PATCH_HIT_CNT_EN
  logic [HIT_CNT_W-1:0] hit_cnt [NUM_PATCH];
  assign ctl_hit_cnt_o = idx_ok ? hit_cnt[ctl_idx_i] : '0;
`else
  assign ctl_hit_cnt_o = '0;
`endif

  for (genvar gi = 0; gi < NUM_PATCH; gi++) begin : g_entry
    patch_entry_t ent_q;
    logic         clr_me;
    logic         wr_me;

    assign clr_me      = clearing && (clr_ptr_q == IDX_W'(gi));
    assign wr_me       = wr_ok && (ctl_idx_i == IDX_W'(gi));
    assign entries[gi] = ent_q;

    always_ff @(posedge clk_i) begin
      if (!rst_ni || clr_me) begin
        ent_q <= '0;
      end else if (wr_me) begin
        ent_q.en      <= ctl_en_i;
        ent_q.match   <= ctl_pat_addr_i;
        ent_q.replace <= ctl_pat_data_i;
      end
    end

`ifdef ADDR_PATCH_HIT_CNT_EN
    logic [HIT_CNT_W-1:0] cnt_q;
    assign hit_cnt[gi] = cnt_q;

    // Counts at the si handshake and sticks at all-ones.
    always_ff @(posedge clk_i) begin
      if (!rst_ni || clr_me || wr_me) begin
        cnt_q <= '0;
      end else if (si_hs && lk_hit && (lk_idx == IDX_W'(gi)) && (cnt_q != '1)) begin
        cnt_q <= cnt_q + HIT_CNT_W'(1);
      end
    end
`endif
  end

endmodule

// File: tb/tb_addr_patch_ctrl.sv
// Scoreboard bench for addr_patch_ctrl: a reference table model predicts each beat at the si
// handshake; the monitor pops and compares when the mi side transfers.
module tb_addr_patch_ctrl;

  localparam int ADDR_W    = 32;
  localparam int NUM_PATCH = 4;
  localparam int IDX_W     = 2;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              patched;
    logic [IDX_W-1:0]  idx;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst_ni;
  logic              si_valid_i;
  logic              si_ready_o;
  logic [ADDR_W-1:0] si_addr_i;
  logic              mi_valid_o;
  logic              mi_ready_i;
  logic [ADDR_W-1:0] mi_addr_o;
  logic              mi_patched_o;
  logic [IDX_W-1:0]  mi_idx_o;
  logic              ctl_we_i;
  logic [IDX_W-1:0]  ctl_idx_i;
  logic              ctl_en_i;
  logic [ADDR_W-1:0] ctl_pat_addr_i;
  logic [ADDR_W-1:0] ctl_pat_data_i;
  logic              ctl_clr_i;
  logic              ctl_busy_o;
  logic [15:0]       ctl_hit_cnt_o;

  addr_patch_ctrl #(
    .ADDR_W    (ADDR_W),
    .NUM_PATCH (NUM_PATCH),
    .IDX_W     (IDX_W)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .si_valid_i     (si_valid_i),
    .si_ready_o     (si_ready_o),
    .si_addr_i      (si_addr_i),
    .mi_valid_o     (mi_valid_o),
    .mi_ready_i     (mi_ready_i),
    .mi_addr_o      (mi_addr_o),
    .mi_patched_o   (mi_patched_o),
    .mi_idx_o       (mi_idx_o),
    .ctl_we_i       (ctl_we_i),
    .ctl_idx_i      (ctl_idx_i),
    .ctl_en_i       (ctl_en_i),
    .ctl_pat_addr_i (ctl_pat_addr_i),
    .ctl_pat_data_i (ctl_pat_data_i),
    .ctl_clr_i      (ctl_clr_i),
    .ctl_busy_o     (ctl_busy_o),
    .ctl_hit_cnt_o  (ctl_hit_cnt_o)
  );

  always #5 clk = ~clk;

  beat_t             sb[$];
  logic              m_en    [NUM_PATCH];
  logic [ADDR_W-1:0] m_match [NUM_PATCH];
  logic [ADDR_W-1:0] m_repl  [NUM_PATCH];
  int                m_cnt   [NUM_PATCH];
  int                n_checks = 0;
  int                n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic beat_t model_lookup(input logic [ADDR_W-1:0] a);
    beat_t b;
    b.addr    = a;
    b.patched = 1'b0;
    b.idx     = '0;
    for (int i = NUM_PATCH - 1; i >= 0; i--) begin
      if (m_en[i] && m_match[i] == a) begin
        b.addr    = m_repl[i];
        b.patched = 1'b1;
        b.idx     = IDX_W'(i);
      end
    end
    return b;
  endfunction

  function automatic int exp_cnt(input int i);
`ifdef ADDR_PATCH_HIT_CNT_EN
    return m_cnt[i];
`else
    return 0 * i;
`endif
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NUM_PATCH; i++) begin
      m_en[i]    = 1'b0;
      m_match[i] = '0;
      m_repl[i]  = '0;
      m_cnt[i]   = 0;
    end
  endtask

  // Inputs are stable at the falling edge, so it is a safe point to see both handshakes.
  always @(negedge clk) begin
    if (!rst_ni) begin
      sb.delete();
    end else begin
      if (mi_valid_o && mi_ready_i) begin
        if (sb.size() == 0) begin
          check_val("sb_underflow", 64'(sb.size()), 64'd1);
        end else begin
          beat_t e;
          beat_t g;
          e = sb.pop_front();
          g = '{addr: mi_addr_o, patched: mi_patched_o, idx: mi_idx_o};
          $display("beat out addr=0x%08h patched=%0d idx=%0d (expected 0x%08h/%0d/%0d)",
                   g.addr, g.patched, g.idx, e.addr, e.patched, e.idx);
          check_val("beat", 64'(g), 64'(e));
        end
      end
      if (si_valid_i && si_ready_o) begin
        beat_t e;
        e = model_lookup(si_addr_i);
        if (e.patched && m_cnt[e.idx] < 16'hFFFF) m_cnt[e.idx]++;
        sb.push_back(e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input int idx, input logic en, input logic [ADDR_W-1:0] pat,
                             input logic [ADDR_W-1:0] data);
    ctl_we_i       = 1'b1;
    ctl_idx_i      = IDX_W'(idx);
    ctl_en_i       = en;
    ctl_pat_addr_i = pat;
    ctl_pat_data_i = data;
    tick();
    ctl_we_i     = 1'b0;
    m_en[idx]    = en;
    m_match[idx] = pat;
    m_repl[idx]  = data;
    m_cnt[idx]   = 0;
  endtask

  // Present one beat and hold it until the controller takes it; si_valid_i stays high on return.
  task automatic send(input logic [ADDR_W-1:0] a);
    bit done = 1'b0;
    si_valid_i = 1'b1;
    si_addr_i  = a;
    for (int t = 0; t < 50 && !done; t++) begin
      if (si_ready_o) done = 1'b1;
      tick();
    end
    if (!done) check_val("send_timeout", 64'(si_ready_o), 64'd1);
  endtask

  task automatic drain();
    si_valid_i = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int busy_cycles;
    logic [ADDR_W-1:0] held_addr;

    rst_ni = 1'b0;  si_valid_i = 1'b0; si_addr_i = '0; mi_ready_i = 1'b1;
    ctl_we_i = 1'b0; ctl_idx_i = '0; ctl_en_i = 1'b0;
    ctl_pat_addr_i = '0; ctl_pat_data_i = '0; ctl_clr_i = 1'b0;
    model_clear();
    repeat (3) tick();

    check_val("rst_mi_valid", 64'(mi_valid_o), 64'd0);
    check_val("rst_mi_addr", 64'(mi_addr_o), 64'd0);
    check_val("rst_mi_patched", 64'(mi_patched_o), 64'd0);
    check_val("rst_mi_idx", 64'(mi_idx_o), 64'd0);
    check_val("rst_busy", 64'(ctl_busy_o), 64'd0);
    check_val("rst_hit_cnt", 64'(ctl_hit_cnt_o), 64'd0);
    rst_ni = 1'b1;
    check_val("rst_si_ready", 64'(si_ready_o), 64'd1);

    // Empty table: address passes through one cycle later.
    send(32'h1000);
    check_val("t1_latency_valid", 64'(mi_valid_o), 64'd1);
    check_val("t1_latency_addr", 64'(mi_addr_o), 64'h1000);
    drain();

    // Single entry, then back-to-back hit and miss.
    write_entry(0, 1'b1, 32'h1000, 32'h8000);
    send(32'h1000);
    send(32'h1004);
    drain();

    // Two entries on the same address: lower index wins.
    write_entry(1, 1'b1, 32'h2000, 32'hA000);
    write_entry(2, 1'b1, 32'h2000, 32'hB000);
    send(32'h2000);
    check_val("t3_addr", 64'(mi_addr_o), 64'hA000);
    check_val("t3_idx", 64'(mi_idx_o), 64'd1);
    drain();
    ctl_idx_i = 2'd1;
    #1 check_val("t3_hit_cnt1", 64'(ctl_hit_cnt_o), 64'(exp_cnt(1)));

    // Back-pressure: output must hold steady and nothing is lost or repeated.
    mi_ready_i = 1'b0;
    si_valid_i = 1'b1;
    si_addr_i  = 32'h2000;
    tick();
    held_addr = model_lookup(32'h2000).addr;
    si_addr_i = 32'h5000;
    for (int c = 0; c < 3; c++) begin
      check_val("t4_si_ready", 64'(si_ready_o), 64'd0);
      check_val("t4_mi_valid", 64'(mi_valid_o), 64'd1);
      check_val("t4_mi_addr", 64'(mi_addr_o), 64'(held_addr));
      tick();
    end
    mi_ready_i = 1'b1;
    tick();
    drain();
    check_val("t4_sb_empty", 64'(sb.size()), 64'd0);

    // Sequenced clear; a write issued mid-clear must not land.
    ctl_clr_i = 1'b1;
    tick();
    ctl_clr_i   = 1'b0;
    busy_cycles = 0;
    for (int c = 0; c < 10 && ctl_busy_o; c++) begin
      check_val("t5_si_ready_busy", 64'(si_ready_o), 64'd0);
      if (c == 1) begin
        ctl_we_i       = 1'b1;
        ctl_idx_i      = 2'd0;
        ctl_en_i       = 1'b1;
        ctl_pat_addr_i = 32'h3000;
        ctl_pat_data_i = 32'h9999;
      end
      busy_cycles++;
      tick();
      ctl_we_i = 1'b0;
    end
    model_clear();
    check_val("t5_busy_cycles", 64'(busy_cycles), 64'(NUM_PATCH));
    check_val("t5_busy_end", 64'(ctl_busy_o), 64'd0);
    send(32'h1000);
    send(32'h2000);
    send(32'h3000);
    drain();
    check_val("t5_sb_empty", 64'(sb.size()), 64'd0);

    // Hit counter, then reset while beats are in flight.
    write_entry(0, 1'b1, 32'h1000, 32'h8000);
    send(32'h1000);
    send(32'h1000);
    send(32'h1000);
    drain();
    ctl_idx_i = 2'd0;
    #1 check_val("t6_hit_cnt0", 64'(ctl_hit_cnt_o), 64'(exp_cnt(0)));

    si_valid_i = 1'b1;
    si_addr_i  = 32'h1000;
    tick();
    tick();
    rst_ni     = 1'b0;
    si_valid_i = 1'b0;
    tick();
    model_clear();
    check_val("t6_rst_mi_valid", 64'(mi_valid_o), 64'd0);
    check_val("t6_rst_mi_addr", 64'(mi_addr_o), 64'd0);
    check_val("t6_rst_mi_patched", 64'(mi_patched_o), 64'd0);
    check_val("t6_rst_busy", 64'(ctl_busy_o), 64'd0);
    check_val("t6_rst_hit_cnt", 64'(ctl_hit_cnt_o), 64'd0);
    rst_ni = 1'b1;
    check_val("t6_si_ready", 64'(si_ready_o), 64'd1);
    send(32'h1000);
    drain();
    check_val("t6_sb_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
